apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
- APB4 completer (slave) that sits directly downstream of the team's APB requester on the shared bus.
- Consumes PSELx/PENABLE/PADDR/PWRITE/PWDATA/PSTRB/PPROT/PNSE.
- Returns PRDATA/PREADY/PSLVERR from a small word-addressed register memory.
- Supports programmable wait states, byte strobes and error signalling, so the requester's transfer, wait and error paths can be exercised end to end.

Parameters:
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width; fixed at 32 for this block.
- DEPTH, 16, number of 32-bit words; must be a power of 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*4.
- WAIT_CYCLES, 1, PREADY-low cycles inserted in every access phase (0..15).
- SECURE_ONLY, 0, when 1, non-secure accesses (PPROT[1]=1) are rejected.

Ports:
- PCLK  in  1  bus clock; all state on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSELx  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PADDR  in  ADDR_WIDTH  byte address.
- PWRITE  in  1  1=write, 0=read.
- PWDATA  in  32  write data.
- PSTRB  in  4  write byte lanes.
- PPROT  in  3  protection attributes.
- PNSE  in  1  non-secure-extension attribute.
- PRDATA  out  32  read data, valid only when PREADY=1 on a good read.
- PREADY  out  1  transfer-complete.
- PSLVERR  out  1  error, valid only when PREADY=1.

Behaviour:
- Reset (async, PRESETn=0): state=IDLE, wait counter=0, memory words=0, PREADY=0, PRDATA=0, PSLVERR=0. Takes effect immediately, including mid-transfer; an in-flight write is discarded.
- States: IDLE, ACCESS.
- IDLE to ACCESS: at the edge where PSELx=1 and PENABLE=0 (setup phase), latch:
  - word index = (PADDR-BASE_ADDR)>>2, truncated to log2(DEPTH);
  - PWRITE;
  - err flag;
  - cnt=WAIT_CYCLES.
- err flag is set if any of:
  - PADDR[1:0]!=0;
  - PADDR<BASE_ADDR or PADDR>=BASE_ADDR+DEPTH*4;
  - PNSE=1;
  - SECURE_ONLY=1 and PPROT[1]=1.
- ACCESS with cnt>0: PREADY=0; cnt decrements by 1 each edge where PSELx=1 and PENABLE=1.
- ACCESS with cnt=0: PREADY=1 and PSLVERR=err.
  - PRDATA = mem[index] for a good read, else 0.
  - Outputs are decoded from registered state only; no combinational path from bus inputs.
- Completion edge (PSELx=1, PENABLE=1, PREADY=1):
  - good write: mem[index] byte k <= PWDATA[8k+7:8k] for each PSTRB[k]=1; other bytes unchanged;
  - errored write: memory unchanged;
  - then state returns to IDLE.
- Latency: WAIT_CYCLES=0 gives the minimum 2-cycle APB transfer. Otherwise 2+WAIT_CYCLES cycles.
- Back-to-back: a setup phase on the cycle after completion is accepted normally; no idle cycle is required.
- Read immediately after a write to the same index returns the new data.
- PSELx deasserted while in ACCESS: abort, return to IDLE, no write, PREADY stays 0.
- PENABLE=1 while in IDLE (no setup seen): ignored; no state change, PREADY stays 0.
- PSTRB is not checked on reads.
- PADDR/PWDATA/PSTRB are sampled at the completion edge for write data; the address comes from the setup latch.

Decomposition:
- Shared package apb_pkg holds:
  - state enum (IDLE, ACCESS);
  - APB_DATA_W=32 and APB_STRB_W=4 constants;
  - err-cause typedef (MISALIGN, RANGE, PNSE, PROT), exposed for assertions and coverage.
- One natural sub-module: apb_slave_decode, combinational. Inputs PADDR, PPROT, PNSE; outputs index and err.
- FSM, wait counter and memory stay in apb_slave_mem.

Test Plan:
- Reset then read addr 0x8 -> PREADY high on 3rd cycle (WAIT_CYCLES=1), PRDATA=0, PSLVERR=0.
- Write 0x8 data 0xDEADBEEF PSTRB=4'b1111, then write 0x8 data 0x11223344 PSTRB=4'b0101, then read 0x8 -> PRDATA=0xDE22BE44.
- Write addr 0x40 (DEPTH=16), read 0x6 (misaligned), read 0x0 with PNSE=1 -> each completes with PSLVERR=1, PRDATA=0, memory unchanged.
- WAIT_CYCLES=3: PREADY low for exactly 3 access cycles then high for 1; a back-to-back write then read to 0x4 returns the written value.
- SECURE_ONLY=1, write 0x0 with PPROT=3'b010 -> PSLVERR=1, no update; same write with PPROT=3'b000 -> PSLVERR=0, data stored.
- PRESETn pulsed low during the wait of a write to 0xC -> outputs 0 immediately, state IDLE; a subsequent read of 0xC returns 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB completer definitions: bus widths, FSM states and error causes.
package apb_pkg;

   localparam int APB_DATA_W = 32;
   localparam int APB_STRB_W = 4;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   // One flag per reason a transfer is answered with PSLVERR.
   typedef struct packed {
      logic prot;          // non-secure access to a secure-only completer
      logic nse;           // PNSE set (realm/root extension not supported)
      logic out_of_range;  // address outside the memory window
      logic misalign;      // byte address not word aligned
   } err_cause_t;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB4 bus bundle between a requester (master) and a completer (slave).
interface apb_slave_mem_if
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
);
   logic                  PSELx;
   logic                  PENABLE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PWRITE;
   logic [APB_DATA_W-1:0] PWDATA;
   logic [APB_STRB_W-1:0] PSTRB;
   logic [2:0]            PPROT;
   logic                  PNSE;
   logic [APB_DATA_W-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSELx, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, PNSE,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSELx, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, PNSE,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_slave_decode.sv
// Address/attribute decode for the APB memory: word index and error flag.
module apb_slave_decode
   import apb_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DEPTH       = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter bit                    SECURE_ONLY = 1'b0,
   localparam int                   IDX_W       = $clog2(DEPTH)
) (
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [2:0]            PPROT,
   input  logic                  PNSE,
   output logic [IDX_W-1:0]      index,
   output logic                  err
);
   // One bit wider so a window ending at the top of the address space does not wrap.
   localparam logic [ADDR_WIDTH:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(DEPTH * 4);

   logic [ADDR_WIDTH-1:0] offset;
   err_cause_t            cause;
   logic                  prot_unused;

   // Only the secure/non-secure bit of PPROT matters here.
   assign prot_unused = PPROT[2] ^ PPROT[0];

   // Decode word index and every error cause from the setup-phase attributes.
   always_comb begin
      offset             = PADDR - BASE_ADDR;
      index              = IDX_W'(offset >> 2);
      cause.misalign     = |PADDR[1:0];
      cause.out_of_range = (PADDR < BASE_ADDR) || ({1'b0, PADDR} >= LIMIT);
      cause.nse          = PNSE;
      cause.prot         = SECURE_ONLY && PPROT[1];
      err                = |cause;
   end

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer backed by a small word memory with wait states, byte strobes
// and PSLVERR signalling.
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    DEPTH       = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                    WAIT_CYCLES = 1,
   parameter bit                    SECURE_ONLY = 1'b0
) (
   input logic            PCLK,
   input logic            PRESETn,
   apb_slave_mem_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);

   state_e                state_q;
   logic [3:0]            cnt_q;
   logic [IDX_W-1:0]      idx_q;
   logic [IDX_W-1:0]      idx_d;
   logic                  write_q;
   logic                  err_q;
   logic                  err_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  setup;
   logic                  ready;
   logic                  done;

   apb_slave_decode #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DEPTH       (DEPTH),
      .BASE_ADDR   (BASE_ADDR),
      .SECURE_ONLY (SECURE_ONLY)
   ) u_decode (
      .PADDR (bus.PADDR),
      .PPROT (bus.PPROT),
      .PNSE  (bus.PNSE),
      .index (idx_d),
      .err   (err_d)
   );

   assign setup = bus.PSELx && !bus.PENABLE;
   assign ready = (state_q == ACCESS) && (cnt_q == 4'd0);
   assign done  = ready && bus.PSELx && bus.PENABLE;

   // Outputs come only from registered state so no bus input reaches them combinationally.
   assign bus.PREADY  = ready;
   assign bus.PSLVERR = ready && err_q;
   assign bus.PRDATA  = (ready && !write_q && !err_q) ? mem[idx_q] : '0;

   // Transfer FSM: latch the request at setup, count wait states, finish or abort.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (setup) begin
                  state_q <= ACCESS;
                  idx_q   <= idx_d;
                  write_q <= bus.PWRITE;
                  err_q   <= err_d;
                  cnt_q   <= 4'(WAIT_CYCLES);
               end
            end
            ACCESS: begin
               if (!bus.PSELx) begin
                  state_q <= IDLE;
               end else if (bus.PENABLE) begin
                  if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                  else               state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Memory: cleared by reset, byte-lane update on a good write completion only.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (done && write_q && !err_q) begin
         for (int k = 0; k < APB_STRB_W; k++) begin
            if (bus.PSTRB[k]) mem[idx_q][8*k +: 8] <= bus.PWDATA[8*k +: 8];
         end
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (1 wait, 3 waits, secure-only with
// no waits) share one driven bus; the selected instance answers.
module tb_apb_slave_mem;
   import apb_pkg::*;

   logic PCLK = 1'b0;
   logic PRESETn;
   always #5 PCLK = ~PCLK;

   int          sel_dut;
   logic        psel, penable, pwrite, pnse;
   logic [31:0] paddr, pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic        ready, slverr;
   logic [31:0] rdata;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      logic        nse;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_waits;
   } stim_t;

   typedef struct {
      string       name;
      logic [31:0] data;
      logic        err;
      int          waits;
   } exp_t;

   typedef struct {
      logic        done;
      logic [31:0] data;
      logic        err;
      int          waits;
   } obs_t;

   exp_t exp_q[$];

   apb_slave_mem_if if_w1 ();
   apb_slave_mem_if if_w3 ();
   apb_slave_mem_if if_sec ();

   assign if_w1.PSELx  = psel && (sel_dut == 0);
   assign if_w3.PSELx  = psel && (sel_dut == 1);
   assign if_sec.PSELx = psel && (sel_dut == 2);
   assign if_w1.PENABLE = penable;  assign if_w3.PENABLE = penable;  assign if_sec.PENABLE = penable;
   assign if_w1.PADDR   = paddr;    assign if_w3.PADDR   = paddr;    assign if_sec.PADDR   = paddr;
   assign if_w1.PWRITE  = pwrite;   assign if_w3.PWRITE  = pwrite;   assign if_sec.PWRITE  = pwrite;
   assign if_w1.PWDATA  = pwdata;   assign if_w3.PWDATA  = pwdata;   assign if_sec.PWDATA  = pwdata;
   assign if_w1.PSTRB   = pstrb;    assign if_w3.PSTRB   = pstrb;    assign if_sec.PSTRB   = pstrb;
   assign if_w1.PPROT   = pprot;    assign if_w3.PPROT   = pprot;    assign if_sec.PPROT   = pprot;
   assign if_w1.PNSE    = pnse;     assign if_w3.PNSE    = pnse;     assign if_sec.PNSE    = pnse;

   always_comb begin
      ready  = if_w1.PREADY;
      slverr = if_w1.PSLVERR;
      rdata  = if_w1.PRDATA;
      if (sel_dut == 1) begin
         ready = if_w3.PREADY;  slverr = if_w3.PSLVERR;  rdata = if_w3.PRDATA;
      end else if (sel_dut == 2) begin
         ready = if_sec.PREADY; slverr = if_sec.PSLVERR; rdata = if_sec.PRDATA;
      end
   end

   apb_slave_mem #(.WAIT_CYCLES(1)) u_w1 (.PCLK(PCLK), .PRESETn(PRESETn), .bus(if_w1));
   apb_slave_mem #(.WAIT_CYCLES(3)) u_w3 (.PCLK(PCLK), .PRESETn(PRESETn), .bus(if_w3));
   apb_slave_mem #(.WAIT_CYCLES(0), .SECURE_ONLY(1'b1)) u_sec (.PCLK(PCLK), .PRESETn(PRESETn), .bus(if_sec));

   // One complete APB transfer; reports completion, data, error and wait count.
   task automatic xfer(input stim_t s, output obs_t o);
      o = '{done: 1'b0, data: 32'h0, err: 1'b0, waits: 0};
      psel = 1'b1; penable = 1'b0; paddr = s.addr; pwrite = s.wr;
      pwdata = s.wdata; pstrb = s.strb; pprot = s.prot; pnse = s.nse;
      @(posedge PCLK); #1;
      penable = 1'b1;
      for (int i = 0; i < 40 && !o.done; i++) begin
         @(negedge PCLK);
         if (ready === 1'b1) begin
            o.done = 1'b1; o.data = rdata; o.err = slverr;
         end else begin
            o.waits++;
         end
      end
      @(posedge PCLK); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic test_reset();
      psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0;
      pstrb = '0; pprot = '0; pnse = 1'b0; sel_dut = 0;
      PRESETn = 1'b0;
      repeat (3) @(posedge PCLK);
      #1 PRESETn = 1'b1;
      @(negedge PCLK);
      for (int d = 0; d < 3; d++) begin
         sel_dut = d;
         #1;
         checks++;
         if (ready !== 1'b0 || slverr !== 1'b0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_dut%0d: ready=%b slverr=%b rdata=%h, expected 0/0/0", d, ready, slverr, rdata);
         end
      end
      sel_dut = 0;
      @(posedge PCLK); #1;
   endtask

   task automatic test_read_after_reset();
      stim_t st[1];
      obs_t  o;
      exp_t  e;
      sel_dut = 0;
      st[0] = '{"rd8_after_reset", 32'h8, 1'b0, 32'h0, 4'h0, 3'b000, 1'b0, 32'h0, 1'b0, 1};
      foreach (st[i]) exp_q.push_back('{st[i].name, st[i].exp_data, st[i].exp_err, st[i].exp_waits});
      foreach (st[i]) begin
         xfer(st[i], o);
         e = exp_q.pop_front();
         checks++;
         if (o.done !== 1'b1 || o.data !== e.data || o.err !== e.err || o.waits != e.waits) begin
            failures++;
            $display("FAIL %s: done=%b data=%h err=%b waits=%0d, expected data=%h err=%b waits=%0d",
                     e.name, o.done, o.data, o.err, o.waits, e.data, e.err, e.waits);
         end
      end
   endtask

   task automatic test_strobes();
      stim_t st[3];
      obs_t  o;
      exp_t  e;
      sel_dut = 0;
      st[0] = '{"wr8_full",   32'h8, 1'b1, 32'hDEADBEEF, 4'b1111, 3'b000, 1'b0, 32'h0, 1'b0, 1};
      st[1] = '{"wr8_lanes",  32'h8, 1'b1, 32'h11223344, 4'b0101, 3'b000, 1'b0, 32'h0, 1'b0, 1};
      st[2] = '{"rd8_merged", 32'h8, 1'b0, 32'h0,        4'b0000, 3'b000, 1'b0, 32'hDE22BE44, 1'b0, 1};
      foreach (st[i]) exp_q.push_back('{st[i].name, st[i].exp_data, st[i].exp_err, st[i].exp_waits});
      foreach (st[i]) begin
         xfer(st[i], o);
         e = exp_q.pop_front();
         checks++;
         if (o.done !== 1'b1 || o.data !== e.data || o.err !== e.err || o.waits != e.waits) begin
            failures++;
            $display("FAIL %s: done=%b data=%h err=%b waits=%0d, expected data=%h err=%b waits=%0d",
                     e.name, o.done, o.data, o.err, o.waits, e.data, e.err, e.waits);
         end
      end
   endtask

   task automatic test_errors();
      stim_t st[8];
      obs_t  o;
      exp_t  e;
      sel_dut = 0;
      st[0] = '{"wr40_range",   32'h40, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b000, 1'b0, 32'h0, 1'b1, 1};
      st[1] = '{"rd6_misalign", 32'h6,  1'b0, 32'h0,        4'h0, 3'b000, 1'b0, 32'h0, 1'b1, 1};
      st[2] = '{"rd0_pnse",     32'h0,  1'b0, 32'h0,        4'h0, 3'b000, 1'b1, 32'h0, 1'b1, 1};
      st[3] = '{"wr9_misalign", 32'h9,  1'b1, 32'h55555555, 4'hF, 3'b000, 1'b0, 32'h0, 1'b1, 1};
      st[4] = '{"rd0_unchanged",32'h0,  1'b0, 32'h0,        4'h0, 3'b000, 1'b0, 32'h0, 1'b0, 1};
      st[5] = '{"rd8_unchanged",32'h8,  1'b0, 32'h0,        4'h0, 3'b000, 1'b0, 32'hDE22BE44, 1'b0, 1};
      st[6] = '{"wr3c_last",    32'h3C, 1'b1, 32'h00000001, 4'hF, 3'b000, 1'b0, 32'h0, 1'b0, 1};
      st[7] = '{"rd3c_last",    32'h3C, 1'b0, 32'h0,        4'h0, 3'b000, 1'b0, 32'h00000001, 1'b0, 1};
      foreach (st[i]) exp_q.push_back('{st[i].name, st[i].exp_data, st[i].exp_err, st[i].exp_waits});
      foreach (st[i]) begin
         xfer(st[i], o);
         e = exp_q.pop_front();
         checks++;
         if (o.done !== 1'b1 || o.data !== e.data || o.err !== e.err || o.waits != e.waits) begin
            failures++;
            $display("FAIL %s: done=%b data=%h err=%b waits=%0d, expected data=%h err=%b waits=%0d",
                     e.name, o.done, o.data, o.err, o.waits, e.data, e.err, e.waits);
         end
      end
   endtask

   task automatic test_penable_idle();
      stim_t s;
      obs_t  o;
      exp_t  e;
      sel_dut = 0;
      psel = 1'b1; penable = 1'b1; paddr = 32'h8; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
      for (int c = 0; c < 3; c++) begin
         @(negedge PCLK);
         checks++;
         if (ready !== 1'b0) begin
            failures++;
            $display("FAIL penable_idle_c%0d: ready=%b, expected 0", c, ready);
         end
      end
      @(posedge PCLK); #1;
      psel = 1'b0; penable = 1'b0;
      s = '{"rd8_after_stray_penable", 32'h8, 1'b0, 32'h0, 4'h0, 3'b000, 1'b0, 32'hDE22BE44, 1'b0, 1};
      exp_q.push_back('{s.name, s.exp_data, s.exp_err, s.exp_waits});
      xfer(s, o);
      e = exp_q.pop_front();
      checks++;
      if (o.done !== 1'b1 || o.data !== e.data || o.err !== e.err || o.waits != e.waits) begin
         failures++;
         $display("FAIL %s: done=%b data=%h err=%b waits=%0d, expected data=%h err=%b waits=%0d",
                  e.name, o.done, o.data, o.err, o.waits, e.data, e.err, e.waits);
      end
   endtask

   task automatic test_back_to_back();
      stim_t st[2];
      obs_t  o;
      exp_t  e;
      sel_dut = 1;
      st[0] = '{"w3_wr4", 32'h4, 1'b1, 32'h0F1E2D3C, 4'hF, 3'b000, 1'b0, 32'h0, 1'b0, 3};
      st[1] = '{"w3_rd4", 32'h4, 1'b0, 32'h0,        4'h0, 3'b000, 1'b0, 32'h0F1E2D3C, 1'b0, 3};
      foreach (st[i]) exp_q.push_back('{st[i].name, st[i].exp_data, st[i].exp_err, st[i].exp_waits});
      foreach (st[i]) begin
         xfer(st[i], o);
         e = exp_q.pop_front();
         checks++;
         if (o.done !== 1'b1 || o.data !== e.data || o.err !== e.err || o.waits != e.waits) begin
            failures++;
            $display("FAIL %s: done=%b data=%h err=%b waits=%0d, expected data=%h err=%b waits=%0d",
                     e.name, o.done, o.data, o.err, o.waits, e.data, e.err, e.waits);
         end
      end
      @(negedge PCLK);
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL w3_ready_one_cycle: ready=%b after completion, expected 0", ready);
      end
   endtask

   task automatic test_abort();
      stim_t s;
      obs_t  o;
      exp_t  e;
      sel_dut = 1;
      psel = 1'b1; penable = 1'b0; paddr = 32'h4; pwrite = 1'b1; pwdata = 32'hBAD0BAD0;
      pstrb = 4'hF; pprot = 3'b000; pnse = 1'b0;
      @(posedge PCLK); #1 penable = 1'b1;
      @(posedge PCLK); #1 psel = 1'b0; penable = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge PCLK);
         checks++;
         if (ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_ready_c%0d: ready=%b, expected 0", c, ready);
         end
      end
      @(posedge PCLK); #1;
      s = '{"w3_rd4_after_abort", 32'h4, 1'b0, 32'h0, 4'h0, 3'b000, 1'b0, 32'h0F1E2D3C, 1'b0, 3};
      exp_q.push_back('{s.name, s.exp_data, s.exp_err, s.exp_waits});
      xfer(s, o);
      e = exp_q.pop_front();
      checks++;
      if (o.done !== 1'b1 || o.data !== e.data || o.err !== e.err || o.waits != e.waits) begin
         failures++;
         $display("FAIL %s: done=%b data=%h err=%b waits=%0d, expected data=%h err=%b waits=%0d",
                  e.name, o.done, o.data, o.err, o.waits, e.data, e.err, e.waits);
      end
   endtask

   task automatic test_secure();
      stim_t st[5];
      obs_t  o;
      exp_t  e;
      sel_dut = 2;
      st[0] = '{"sec_wr0_nonsecure", 32'h0, 1'b1, 32'hA5A5A5A5, 4'hF, 3'b010, 1'b0, 32'h0, 1'b1, 0};
      st[1] = '{"sec_rd0_untouched", 32'h0, 1'b0, 32'h0,        4'h0, 3'b000, 1'b0, 32'h0, 1'b0, 0};
      st[2] = '{"sec_wr0_secure",    32'h0, 1'b1, 32'h5A5A5A5A, 4'hF, 3'b000, 1'b0, 32'h0, 1'b0, 0};
      st[3] = '{"sec_rd0_stored",    32'h0, 1'b0, 32'h0,        4'h0, 3'b000, 1'b0, 32'h5A5A5A5A, 1'b0, 0};
      st[4] = '{"sec_rd0_nonsecure", 32'h0, 1'b0, 32'h0,        4'h0, 3'b010, 1'b0, 32'h0, 1'b1, 0};
      foreach (st[i]) exp_q.push_back('{st[i].name, st[i].exp_data, st[i].exp_err, st[i].exp_waits});
      foreach (st[i]) begin
         xfer(st[i], o);
         e = exp_q.pop_front();
         checks++;
         if (o.done !== 1'b1 || o.data !== e.data || o.err !== e.err || o.waits != e.waits) begin
            failures++;
            $display("FAIL %s: done=%b data=%h err=%b waits=%0d, expected data=%h err=%b waits=%0d",
                     e.name, o.done, o.data, o.err, o.waits, e.data, e.err, e.waits);
         end
      end
   endtask

   task automatic test_reset_mid();
      stim_t st[3];
      obs_t  o;
      exp_t  e;
      sel_dut = 0;
      st[0] = '{"wrc_before_reset", 32'hC, 1'b1, 32'hCAFEF00D, 4'hF, 3'b000, 1'b0, 32'h0, 1'b0, 1};
      exp_q.push_back('{st[0].name, st[0].exp_data, st[0].exp_err, st[0].exp_waits});
      xfer(st[0], o);
      e = exp_q.pop_front();
      checks++;
      if (o.done !== 1'b1 || o.data !== e.data || o.err !== e.err || o.waits != e.waits) begin
         failures++;
         $display("FAIL %s: done=%b data=%h err=%b waits=%0d, expected data=%h err=%b waits=%0d",
                  e.name, o.done, o.data, o.err, o.waits, e.data, e.err, e.waits);
      end
      // Read 0xC up to its completion cycle, then reset while PREADY is high.
      psel = 1'b1; penable = 1'b0; paddr = 32'hC; pwrite = 1'b0; pstrb = 4'h0;
      @(posedge PCLK); #1 penable = 1'b1;
      @(negedge PCLK);
      @(negedge PCLK);
      checks++;
      if (ready !== 1'b1 || rdata !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL rdc_before_reset: ready=%b rdata=%h, expected 1/cafef00d", ready, rdata);
      end
      PRESETn = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b0 || slverr !== 1'b0 || rdata !== 32'h0) begin
         failures++;
         $display("FAIL async_reset_outputs: ready=%b slverr=%b rdata=%h, expected 0/0/0", ready, slverr, rdata);
      end
      @(posedge PCLK); #1 psel = 1'b0; penable = 1'b0;
      @(posedge PCLK); #1 PRESETn = 1'b1;
      // Write 0xC, reset during its wait cycle: the write must be lost.
      psel = 1'b1; penable = 1'b0; paddr = 32'hC; pwrite = 1'b1; pwdata = 32'h12345678; pstrb = 4'hF;
      @(posedge PCLK); #1 penable = 1'b1;
      @(negedge PCLK);
      PRESETn = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b0 || slverr !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_wait: ready=%b slverr=%b, expected 0/0", ready, slverr);
      end
      @(posedge PCLK); #1 psel = 1'b0; penable = 1'b0;
      @(posedge PCLK); #1 PRESETn = 1'b1;
      st[1] = '{"rdc_after_reset", 32'hC, 1'b0, 32'h0, 4'h0, 3'b000, 1'b0, 32'h0, 1'b0, 1};
      st[2] = '{"rd8_after_reset", 32'h8, 1'b0, 32'h0, 4'h0, 3'b000, 1'b0, 32'h0, 1'b0, 1};
      for (int i = 1; i < 3; i++) exp_q.push_back('{st[i].name, st[i].exp_data, st[i].exp_err, st[i].exp_waits});
      for (int i = 1; i < 3; i++) begin
         xfer(st[i], o);
         e = exp_q.pop_front();
         checks++;
         if (o.done !== 1'b1 || o.data !== e.data || o.err !== e.err || o.waits != e.waits) begin
            failures++;
            $display("FAIL %s: done=%b data=%h err=%b waits=%0d, expected data=%h err=%b waits=%0d",
                     e.name, o.done, o.data, o.err, o.waits, e.data, e.err, e.waits);
         end
      end
   endtask

   initial begin
      test_reset();
      test_read_after_reset();
      test_strobes();
      test_errors();
      test_penable_idle();
      test_back_to_back();
      test_abort();
      test_secure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
